// File: rtl/ex_mem_pkg.sv
// Shared widths, payload layout and skid-buffer state names for the EX/MEM pipeline stage.
package ex_mem_pkg;

    localparam int N  = 64;
    localparam int RW = 5;

    localparam logic [RW-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [N-1:0]  result;
        logic [N-1:0]  store_data;
        logic [RW-1:0] rd;
        logic          mem_read;
        logic          mem_write;
        logic          reg_write;
        logic          mem_to_reg;
        logic          pc_src;
        logic [N-1:0]  pc_target;
    } ex_mem_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // LEGv8 redirect: B always redirects, CBZ-style branches redirect on a zero result.
    function automatic logic resolve_pc_src(input logic branch, input logic uncond, input logic zero);
        return uncond | (branch & zero);
    endfunction

endpackage

// File: rtl/ex_mem_stage_skid.sv
// Generic 2-entry skid buffer: head register H drives the outputs, skid register S absorbs
// one cycle of backpressure so in_ready depends only on registered state.
//
//   state    | meaning
//   ST_EMPTY | H and S empty
//   ST_ONE   | H holds the head entry, S empty
//   ST_TWO   | H and S both hold entries, in_ready low
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] h_q, h_d;
    logic [W-1:0] s_q, s_d;
    logic         accept;
    logic         pop;

    always_comb begin
        accept  = in_valid && (state_q != ST_TWO);
        pop     = (state_q != ST_EMPTY) && out_ready;
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    h_d     = in_data;
                end
            end
            ST_ONE: begin
                if (pop && accept) begin
                    h_d = in_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    state_d = ST_TWO;
                    s_d     = in_data;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    h_d     = s_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over a same-cycle accept; stale payload is harmless once invalid.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            h_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
        end
    end

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = h_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: resolves the branch decision at capture and buffers entries for MEM.
// Build with EX_MEM_FWD_EN defined to add the fwd_* ports feeding the EX forwarding mux.
module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_zero,
    input  logic [N-1:0]  store_data,
    input  logic [RW-1:0] rd,
    input  logic [N-1:0]  branch_target,
    input  logic          ctl_mem_read,
    input  logic          ctl_mem_write,
    input  logic          ctl_reg_write,
    input  logic          ctl_mem_to_reg,
    input  logic          ctl_branch,
    input  logic          ctl_uncond,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic [N-1:0]  out_store_data,
    output logic [RW-1:0] out_rd,
    output logic          out_mem_read,
    output logic          out_mem_write,
    output logic          out_reg_write,
    output logic          out_mem_to_reg,
    output logic          out_pc_src,
    output logic [N-1:0]  out_pc_target
`ifdef EX_MEM_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_rd,
    output logic [N-1:0]  fwd_data
`endif
);

    ex_mem_payload_t in_pl;
    ex_mem_payload_t out_pl;

    always_comb begin
        in_pl            = '0;
        in_pl.result     = alu_result;
        in_pl.store_data = store_data;
        in_pl.rd         = rd;
        in_pl.mem_read   = ctl_mem_read;
        in_pl.mem_write  = ctl_mem_write;
        in_pl.reg_write  = ctl_reg_write;
        in_pl.mem_to_reg = ctl_mem_to_reg;
        in_pl.pc_src     = resolve_pc_src(ctl_branch, ctl_uncond, alu_zero);
        in_pl.pc_target  = branch_target;
    end

    pipe_skid_buf #(
        .W($bits(ex_mem_payload_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_pl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_pl)
    );

    assign out_result     = out_pl.result;
    assign out_store_data = out_pl.store_data;
    assign out_rd         = out_pl.rd;
    assign out_mem_read   = out_pl.mem_read;
    assign out_mem_write  = out_pl.mem_write;
    assign out_reg_write  = out_pl.reg_write;
    assign out_mem_to_reg = out_pl.mem_to_reg;
    assign out_pc_src     = out_pl.pc_src;
    assign out_pc_target  = out_pl.pc_target;

`ifdef EX_MEM_FWD_EN
    // Loads are excluded: their value only exists after the memory access.
    assign fwd_valid = out_valid & out_pl.reg_write & ~out_pl.mem_to_reg & (out_pl.rd != XZR);
    assign fwd_rd    = out_pl.rd;
    assign fwd_data  = out_pl.result;
`endif

endmodule
